ehl_ahb_matrix_in_buf: RTL
==========================

// Module: ehl_ahb_matrix_in_buf
// PURPOSE
//  Buffered AHB matrix input stage with one instance per master port. Decodes haddr against SNUM
//  packed base/mask windows and requests the target output stage (arbiter).
//  Holds the address phase in a register until the target grants it, and stalls the master meanwhile.
//  Routes the data-phase response back to the master and contains a built-in default slave.
// PARAMETERS
//  SNUM      4        number of slaves, 1..32
//  AW        32       address width
//  DW        32       data width
//  SLV_BASE  {SNUM*AW{1'b0}}  packed bases, slave i at [i*AW+:AW]
//  SLV_MASK  {SNUM*AW{1'b0}}  packed masks, same packing
// PORTS
//  hclk       in   1        clock
//  hresetn    in   1        asynchronous active-low reset
//  haddr      in   AW       master address
//  htrans     in   2        master transfer type
//  hwrite     in   1        master write
//  hsize      in   3        master size
//  hburst     in   3        master burst
//  hprot      in   4        master protection
//  route      in   SNUM     per-slave enable; 0 forces a miss for that slave
//  om_hready  out  1        hready to master
//  om_hrdata  out  DW       read data to master
//  om_hresp   out  2        response to master (00 OKAY, 01 ERROR)
//  os_req     out  SNUM     one-hot request to output stages
//  is_gnt     in   SNUM     output stage i takes the address phase this cycle
//  os_haddr   out  AW       address to slaves (shared by all output stages)
//  os_htrans  out  2        transfer type to slaves; 00 when os_req==0
//  os_hwrite/os_hsize/os_hburst/os_hprot  out  1/3/3/4  control to slaves
//  is_hrdata  in   SNUM*DW  slave read data
//  is_hready  in   SNUM     slave hready
//  is_hresp   in   SNUM*2   slave response
// BEHAVIOUR
//  - Decode: hit[i] = ((haddr & MASK_i) == BASE_i) & route[i]. The lowest hit index wins. No hit selects the default slave.
//  - Accept: a transfer is accepted when htrans[1]==1 and om_hready==1. IDLE and BUSY are never forwarded.
//    Accepting IDLE or BUSY gives a zero-wait OKAY on the next data phase.
//  - States:
//    IDLE: no data phase outstanding.
//    PEND: address held, waiting for grant.
//    DATA: data phase in slave dsel.
//    ERR1, ERR2: default slave response.
//  - Accept cycle, mapped slave k:
//    os_req[k]=1 combinationally. os_* carry the live master signals (bypass).
//    Address and control are always captured into the hold register.
//    If is_gnt[k]=1 -> DATA, dsel=k. Otherwise -> PEND.
//  - PEND: os_req[k]=1 and os_* come from the hold register; om_hready=0, om_hresp=00.
//    is_gnt[k]=1 -> DATA next cycle.
//  - DATA: om_hready, om_hrdata and om_hresp are muxed from is_*[dsel].
//    When is_hready[dsel]=1, a new accept in the same cycle goes to PEND/DATA/ERR1; otherwise -> IDLE.
//  - Default slave hit: os_req=0 and no grant is needed. Next cycle -> ERR1 (see CONFIGURATION).
//  - In IDLE and PEND: om_hrdata=0 and om_hresp=00. In IDLE: om_hready=1.
//  - Reset: state IDLE, hold register 0, dsel 0, os_req 0, os_htrans 00, om_hready 1, om_hresp 00, om_hrdata 0.
//    An assertion in PEND drops os_req asynchronously.
//  - At most one os_req bit is high in any cycle.
// CONFIGURATION
//  EHL_AHB_MTX_IN_DECERR_EN
//    Defined: default-slave access gives the 2-cycle AHB ERROR.
//      ERR1: om_hready=0, om_hresp=01.
//      ERR2: om_hready=1, om_hresp=01; accepts are allowed here.
//    Undefined: default-slave access completes in one zero-wait OKAY cycle with om_hrdata=0 (RAZ/WI).
//      ERR1 and ERR2 are unused.
// STRUCTURE
//  - ehl_ahb_defines.vh: HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HRESP codes, state encodings.
//  - Sub-module ehl_ahb_addr_dec (SNUM, AW, SLV_BASE, SLV_MASK): produces hit vector, priority one-hot sel and miss flag.
//  - Top level: FSM, hold register, response mux.
// TESTING
//  SNUM=4, slave1 base 0x1000_0000 mask 0xF000_0000, slave2 base 0x2000_0000 mask 0xF000_0000, DECERR_EN on unless stated.
//  1. NONSEQ 0x1000_0004 with is_gnt[1]=1 -> os_req=0010 with live os_haddr in the same cycle.
//     Next cycle om_hready=is_hready[1] and om_hrdata=is_hrdata[1].
//  2. Same access with is_gnt[1]=0 for 3 cycles while master moves on to 0x2000_0000 ->
//     om_hready=0 for 3 cycles and os_haddr stays 0x1000_0004; DATA after the grant.
//  3. NONSEQ 0xF000_0000 -> os_req=0000, then om_hready 0 then 1 with om_hresp=01 both cycles.
//     With the macro undefined: om_hready=1, om_hresp=00, om_hrdata=0.
//  4. Slave0 and slave2 both set to base 0x2000_0000 mask 0xF000_0000 -> access 0x2000_0010 gives os_req=0001.
//  5. route=1101 with access 0x1000_0000 -> default slave ERROR and os_req=0000.
//  6. hresetn low in PEND -> os_req=0000 and om_hready=1 immediately.
//     After release, state IDLE and a new NONSEQ is accepted.

Source files
------------

// File: rtl/ehl_ahb_matrix_in_buf_pkg.sv
// ehl_ahb_matrix_in_buf_pkg: shared AHB codes, input-stage FSM states and one-hot index helper
package ehl_ahb_matrix_in_buf_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  typedef enum logic [2:0] {ST_IDLE, ST_PEND, ST_DATA, ST_ERR1, ST_ERR2} state_t;
  function automatic logic [4:0] oh2idx(input logic [31:0] oh);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r |= oh[i] ? 5'(i) : 5'd0;
    return r;
  endfunction
endpackage

// File: rtl/ehl_ahb_addr_dec.sv
// ehl_ahb_addr_dec: base/mask window decode with lowest-index priority and miss flag
module ehl_ahb_addr_dec #(
  parameter int SNUM = 4,
  parameter int AW = 32,
  parameter logic [SNUM*AW-1:0] SLV_BASE = {SNUM*AW{1'b0}},
  parameter logic [SNUM*AW-1:0] SLV_MASK = {SNUM*AW{1'b0}}
) (
  input  logic [AW-1:0]   haddr,
  input  logic [SNUM-1:0] route,
  output logic [SNUM-1:0] sel,
  output logic            miss
);
  logic [SNUM-1:0] hit;
  // per-window match gated by the route enable
  always_comb begin
    hit = '0;
    for (int i = 0; i < SNUM; i++) hit[i] = ((haddr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) & route[i];
  end
  assign sel  = hit & (~hit + SNUM'(1));
  assign miss = ~|hit;
endmodule

// File: rtl/ehl_ahb_matrix_in_buf.sv
// ehl_ahb_matrix_in_buf: buffered AHB matrix input stage; EHL_AHB_MTX_IN_DECERR_EN enables default-slave ERROR
module ehl_ahb_matrix_in_buf
  import ehl_ahb_matrix_in_buf_pkg::*;
#(
  parameter int SNUM = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [SNUM*AW-1:0] SLV_BASE = {SNUM*AW{1'b0}},
  parameter logic [SNUM*AW-1:0] SLV_MASK = {SNUM*AW{1'b0}}
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic [AW-1:0]   haddr,
  input  logic [1:0]      htrans,
  input  logic            hwrite,
  input  logic [2:0]      hsize,
  input  logic [2:0]      hburst,
  input  logic [3:0]      hprot,
  input  logic [SNUM-1:0] route,
  output logic            om_hready,
  output logic [DW-1:0]   om_hrdata,
  output logic [1:0]      om_hresp,
  output logic [SNUM-1:0] os_req,
  input  logic [SNUM-1:0] is_gnt,
  output logic [AW-1:0]   os_haddr,
  output logic [1:0]      os_htrans,
  output logic            os_hwrite,
  output logic [2:0]      os_hsize,
  output logic [2:0]      os_hburst,
  output logic [3:0]      os_hprot,
  input  logic [SNUM*DW-1:0] is_hrdata,
  input  logic [SNUM-1:0] is_hready,
  input  logic [SNUM*2-1:0] is_hresp
);
  localparam int SW = (SNUM > 1) ? $clog2(SNUM) : 1;
  state_t state_q, state_d;
  logic [SW-1:0] dsel_q, dsel_d;
  logic [AW-1:0] haddr_q;
  logic [1:0] htrans_q;
  logic hwrite_q;
  logic [2:0] hsize_q, hburst_q;
  logic [3:0] hprot_q;
  logic [SNUM-1:0] sel;
  logic miss, rdy, accept, gnt, pend;
  ehl_ahb_addr_dec #(.SNUM(SNUM), .AW(AW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_dec (
    .haddr(haddr),
    .route(route),
    .sel(sel),
    .miss(miss)
  );
  assign pend   = state_q == ST_PEND;
  assign rdy    = (state_q == ST_DATA) ? is_hready[dsel_q] : (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign accept = hresetn & htrans[1] & rdy;
  assign gnt    = |(is_gnt & os_req);
  // FSM state and selected slave register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      dsel_q  <= '0;
    end else begin
      state_q <= state_d;
      dsel_q  <= dsel_d;
    end
  end
  // address-phase hold register, loaded on every accepted transfer
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr_q  <= '0;
      htrans_q <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      hburst_q <= '0;
      hprot_q  <= '0;
    end else if (accept) begin
      haddr_q  <= haddr;
      htrans_q <= htrans;
      hwrite_q <= hwrite;
      hsize_q  <= hsize;
      hburst_q <= hburst;
      hprot_q  <= hprot;
    end
  end
  // next state: wait for grant in PEND, otherwise follow the accept/decode result whenever the master sees ready
  always_comb begin
    state_d = state_q;
    dsel_d  = dsel_q;
    if (pend) state_d = gnt ? ST_DATA : ST_PEND;
    else if (state_q == ST_ERR1) state_d = ST_ERR2;
    else if (rdy) begin
      state_d = ST_IDLE;
      if (accept && !miss) begin
        state_d = gnt ? ST_DATA : ST_PEND;
        dsel_d  = SW'(oh2idx(32'(sel)));
      end
`ifdef EHL_AHB_MTX_IN_DECERR_EN
      else if (accept) state_d = ST_ERR1;
`endif
    end
  end
  // outputs: response mux back to the master, live or held address phase towards the slaves
  always_comb begin
    om_hready = rdy;
    om_hresp  = (state_q == ST_DATA) ? is_hresp[2*dsel_q +: 2] :
                (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    om_hrdata = (state_q == ST_DATA) ? is_hrdata[DW*dsel_q +: DW] : '0;
    os_req    = pend ? SNUM'(1) << dsel_q : accept ? sel : '0;
    os_haddr  = pend ? haddr_q : haddr;
    os_hwrite = pend ? hwrite_q : hwrite;
    os_hsize  = pend ? hsize_q : hsize;
    os_hburst = pend ? hburst_q : hburst;
    os_hprot  = pend ? hprot_q : hprot;
    os_htrans = (os_req == '0) ? HTRANS_IDLE : pend ? htrans_q : htrans;
  end
endmodule
